mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the single-issue MIPS-subset core. It sequences instruction fetch, decode, execute, memory access and write-back over shared datapath resources: PC, IR, GRF, ALU, immediate extender and data memory. It drives every datapath write enable and mux select, including the extender mode `EOp`. It handshakes with instruction and data memory through req/ack pairs.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk  in  1  sole clock, rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `op  in  6  IR[31:26], valid from DCD onward`
- `funct  in  6  IR[5:0]`
- `zero  in  1  ALU equality flag, valid in EXE`
- `imem_ack  in  1  instruction word available this cycle`
- `dmem_ack  in  1  data access completes this cycle`
- `imem_req  out  1  fetch request`
- `dmem_req  out  1  data access request`
- `pc_wr, ir_wr, reg_wr, mem_wr  out  1 each  write enables`
- `npc_op  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 GRF[rs]`
- `eop  out  2  00 sign, 01 zero, 10 load-upper, 11 sign<<2`
- `alu_src  out  1  0 GRF[rt], 1 extended immediate`
- `alu_op  out  3  000 add, 001 sub, 010 or, 011 pass-B`
- `reg_dst  out  2  00 rt, 01 rd, 10 $31`
- `wd_sel  out  2  00 ALU, 01 memory, 10 PC+4`
- `illegal  out  1  one-cycle pulse on unsupported opcode or funct`
- `instr_cnt  out  CNT_W  retired-instruction count`

## Operation
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr. `sll $0,$0,0` (nop) retires through WB with reg_wr to $0.
- States: FETCH, DCD, EXE, MEM, WB. The state is registered. All outputs are combinational from state, registered op/funct, `zero` and the acks.
- FETCH: `imem_req`=1. Stays in FETCH until `imem_ack`. In the ack cycle: `ir_wr`=1, `pc_wr`=1, `npc_op`=00, next state is DCD.
- DCD:
  - j: `pc_wr`=1, `npc_op`=10. Retire, go to FETCH.
  - jal: adds `reg_wr`=1, `reg_dst`=10, `wd_sel`=10. Retire, go to FETCH.
  - jr: `pc_wr`=1, `npc_op`=11. Retire, go to FETCH.
  - Unsupported op/funct: `illegal`=1. Retire as nop, go to FETCH.
  - All other instructions go to EXE.
- EXE:
  - addu/subu: `alu_src`=0, `alu_op` add/sub, go to WB.
  - ori: `eop`=01, `alu_src`=1, `alu_op`=or, go to WB.
  - lui: `eop`=10, `alu_src`=1, `alu_op`=pass-B, go to WB.
  - lw/sw: `eop`=00, `alu_src`=1, `alu_op`=add, go to MEM.
  - beq: `alu_op`=sub. If `zero`: `pc_wr`=1, `npc_op`=01, `eop`=11. Retire either way, go to FETCH.
- MEM: `dmem_req`=1 until `dmem_ack`.
  - sw: in the ack cycle `mem_wr`=1, retire, go to FETCH.
  - lw: go to WB on ack.
- WB: `reg_wr`=1. `reg_dst` is 01 for R-type, otherwise 00. `wd_sel` is 01 for lw, otherwise 00. Retire, go to FETCH.
- `eop`, `alu_src` and `alu_op` hold their EXE values through MEM and WB. In FETCH/DCD they default to 00/0/000.
- Retire: `instr_cnt` increments by 1 on the clock edge leaving the final state. It wraps modulo 2^CNT_W.

## Timing
- Reset (`rst_n` low, any state): state goes to FETCH immediately. `instr_cnt`=0. All outputs are forced 0, including `imem_req`.
- First cycle after deassertion: `imem_req`=1.
- Reset mid-instruction aborts it: no partial write, no count.
- Latency with zero-wait acks, including the ack cycle:
  - j/jr/jal/illegal: 2 cycles.
  - beq: 3 cycles.
  - R/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle adds exactly one cycle.
- Request signals stay high and stable until their ack. An ack arriving while the matching req is low is ignored.
- `illegal` is high only in the DCD cycle. No write enable is asserted in that cycle.

## Structure
- `mc_pkg` holds:
  - state enum;
  - opcode/funct constants: R=000000, ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, j=000010, jal=000011; funct addu=100001, subu=100011, jr=001000;
  - encodings for `eop`, `npc_op`, `alu_op`, `reg_dst`, `wd_sel`.
- Sub-module `mc_decode`: combinational op/funct to instruction-class one-hot plus `illegal`. It is instantiated once in `mc_ctrl`.

## Test plan
- Reset release with zero-wait imem, IR=ori $1,$0,0x8000: FETCH→DCD→EXE→WB. `eop`=01 in EXE/WB, `reg_wr` only in WB. `instr_cnt`=1 after the 4th cycle.
- lw with `dmem_ack` delayed 3 cycles: `dmem_req` held 4 cycles, `reg_wr` pulse with `wd_sel`=01 after the ack. Total 8 cycles.
- beq with `zero`=1, then `zero`=0: first asserts `pc_wr`, `npc_op`=01, `eop`=11 in EXE; second has no `pc_wr`. Both return to FETCH after 3 cycles.
- jal: DCD asserts `pc_wr`, `npc_op`=10, `reg_wr`, `reg_dst`=10, `wd_sel`=10 together. Next cycle `imem_req`=1.
- op=111111: `illegal` pulses one cycle, no write enable, `instr_cnt` increments, next fetch proceeds.
- `rst_n` pulled low in MEM of sw before the ack: `mem_wr` never asserted, `instr_cnt`=0, FETCH after release.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS-subset controller.
//   state_t     - FSM states (FETCH, DCD, EXE, MEM, WB)
//   icls_t      - one-hot instruction class produced by mc_decode
//   ex_ctrl_t   - execute-phase controls (eop, alu_src, alu_op) held through MEM/WB
//   OP_*/FN_*   - opcode and funct constants
//   EOP_*, NPC_*, ALU_*, RDST_*, WD_* - datapath select encodings
package mc_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned NPC_W    = 2;
    localparam int unsigned EOP_W    = 2;
    localparam int unsigned ALU_W    = 3;
    localparam int unsigned RDST_W   = 2;
    localparam int unsigned WD_W     = 2;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH = 3'd0,
        ST_DCD   = 3'd1,
        ST_EXE   = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_R   = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI = 6'b001111;
    localparam logic [OP_W-1:0] OP_J   = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL = 6'b000011;

    // R-type funct codes (IR[5:0]); funct 0 is sll, accepted only as the nop
    localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

    // Immediate extender modes
    localparam logic [EOP_W-1:0] EOP_SIGN     = 2'b00;
    localparam logic [EOP_W-1:0] EOP_ZERO     = 2'b01;
    localparam logic [EOP_W-1:0] EOP_LUI      = 2'b10;
    localparam logic [EOP_W-1:0] EOP_SIGN_SL2 = 2'b11;

    // Next-PC source
    localparam logic [NPC_W-1:0] NPC_PC4 = 2'b00;
    localparam logic [NPC_W-1:0] NPC_BR  = 2'b01;
    localparam logic [NPC_W-1:0] NPC_JMP = 2'b10;
    localparam logic [NPC_W-1:0] NPC_REG = 2'b11;

    // ALU operation
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'b010;
    localparam logic [ALU_W-1:0] ALU_PASSB = 3'b011;

    // GRF write-address source
    localparam logic [RDST_W-1:0] RDST_RT = 2'b00;
    localparam logic [RDST_W-1:0] RDST_RD = 2'b01;
    localparam logic [RDST_W-1:0] RDST_RA = 2'b10;

    // GRF write-data source
    localparam logic [WD_W-1:0] WD_ALU = 2'b00;
    localparam logic [WD_W-1:0] WD_MEM = 2'b01;
    localparam logic [WD_W-1:0] WD_PC4 = 2'b10;

    // One-hot instruction class; all-zero means unsupported
    typedef struct packed {
        logic addu;
        logic subu;
        logic nop;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } icls_t;

    typedef struct packed {
        logic [EOP_W-1:0] eop;
        logic             alu_src;
        logic [ALU_W-1:0] alu_op;
    } ex_ctrl_t;

    // Register-format instructions write rd rather than rt
    function automatic logic is_rtype(input icls_t c);
        return c.addu | c.subu | c.nop | c.jr;
    endfunction

    // Execute-phase controls for a class; beq's taken-branch eop is added by the FSM
    function automatic ex_ctrl_t ex_ctrl(input icls_t c);
        ex_ctrl_t x;
        x.eop     = EOP_SIGN;
        x.alu_src = 1'b0;
        x.alu_op  = ALU_ADD;
        if (c.subu || c.beq) begin
            x.alu_op = ALU_SUB;
        end else if (c.ori) begin
            x.eop     = EOP_ZERO;
            x.alu_src = 1'b1;
            x.alu_op  = ALU_OR;
        end else if (c.lui) begin
            x.eop     = EOP_LUI;
            x.alu_src = 1'b1;
            x.alu_op  = ALU_PASSB;
        end else if (c.lw || c.sw) begin
            x.alu_src = 1'b1;
        end
        return x;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/funct decode into a one-hot instruction class.
//   op        in  IR[31:26]
//   funct     in  IR[5:0]
//   cls_c     out one-hot instruction class (all zero when unsupported)
//   illegal_c out unsupported opcode, or unsupported funct under the R opcode
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output icls_t           cls_c,
    output logic            illegal_c
);

    always_comb begin
        cls_c = '0;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADDU: cls_c.addu = 1'b1;
                    FN_SUBU: cls_c.subu = 1'b1;
                    FN_JR:   cls_c.jr   = 1'b1;
                    FN_SLL:  cls_c.nop  = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls_c.ori = 1'b1;
            OP_LW:   cls_c.lw  = 1'b1;
            OP_SW:   cls_c.sw  = 1'b1;
            OP_BEQ:  cls_c.beq = 1'b1;
            OP_LUI:  cls_c.lui = 1'b1;
            OP_J:    cls_c.j   = 1'b1;
            OP_JAL:  cls_c.jal = 1'b1;
            default: ;
        endcase
        illegal_c = (cls_c == '0);
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit (FETCH, DCD, EXE, MEM, WB) for the MIPS-subset core.
//   clk, rst_n          clock, asynchronous active-low reset
//   op, funct           IR fields (held by the datapath IR from DCD onward)
//   zero                ALU equality flag, used in EXE of beq
//   imem_ack, dmem_ack  memory handshakes; ignored while the matching request is low
//   imem_req, dmem_req  memory requests, held until acknowledged
//   pc_wr, ir_wr, reg_wr, mem_wr  datapath write enables
//   npc_op, eop, alu_src, alu_op, reg_dst, wd_sel  datapath selects
//   illegal             one-cycle pulse in DCD for unsupported instructions
//   instr_cnt           retired-instruction counter, wraps
// Control outputs are combinational from state, IR fields, zero and the acks;
// only the state and instr_cnt are registered.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   funct,
    input  logic              zero,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              pc_wr,
    output logic              ir_wr,
    output logic              reg_wr,
    output logic              mem_wr,
    output logic [NPC_W-1:0]  npc_op,
    output logic [EOP_W-1:0]  eop,
    output logic              alu_src,
    output logic [ALU_W-1:0]  alu_op,
    output logic [RDST_W-1:0] reg_dst,
    output logic [WD_W-1:0]   wd_sel,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_cnt
);

    state_t   state;
    state_t   state_nxt;
    logic     retire_c;
    icls_t    cls;
    logic     dec_illegal;
    ex_ctrl_t ex;

    mc_decode u_decode (
        .op        (op),
        .funct     (funct),
        .cls_c     (cls),
        .illegal_c (dec_illegal)
    );

    assign ex = ex_ctrl(cls);

    // State register; reset returns to FETCH and abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (retire_c) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // Next state and control outputs; everything held at 0 while reset is asserted
    always_comb begin
        state_nxt = state;
        retire_c  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_wr    = 1'b0;
        npc_op    = NPC_PC4;
        eop       = EOP_SIGN;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        reg_dst   = RDST_RT;
        wd_sel    = WD_ALU;
        illegal   = 1'b0;

        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_wr     = 1'b1;
                        pc_wr     = 1'b1;
                        npc_op    = NPC_PC4;
                        state_nxt = ST_DCD;
                    end
                end

                ST_DCD: begin
                    // Jumps and illegal instructions finish here; the rest need the ALU
                    if (dec_illegal) begin
                        illegal   = 1'b1;
                        retire_c  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else if (cls.j || cls.jal) begin
                        pc_wr     = 1'b1;
                        npc_op    = NPC_JMP;
                        if (cls.jal) begin
                            reg_wr  = 1'b1;
                            reg_dst = RDST_RA;
                            wd_sel  = WD_PC4;
                        end
                        retire_c  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else if (cls.jr) begin
                        pc_wr     = 1'b1;
                        npc_op    = NPC_REG;
                        retire_c  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_EXE;
                    end
                end

                ST_EXE: begin
                    eop     = ex.eop;
                    alu_src = ex.alu_src;
                    alu_op  = ex.alu_op;
                    if (cls.beq) begin
                        // Taken branch: extender supplies the word offset shifted left by 2
                        if (zero) begin
                            pc_wr  = 1'b1;
                            npc_op = NPC_BR;
                            eop    = EOP_SIGN_SL2;
                        end
                        retire_c  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else if (cls.lw || cls.sw) begin
                        state_nxt = ST_MEM;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end

                ST_MEM: begin
                    eop      = ex.eop;
                    alu_src  = ex.alu_src;
                    alu_op   = ex.alu_op;
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        if (cls.sw) begin
                            mem_wr    = 1'b1;
                            retire_c  = 1'b1;
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_WB;
                        end
                    end
                end

                ST_WB: begin
                    eop       = ex.eop;
                    alu_src   = ex.alu_src;
                    alu_op    = ex.alu_op;
                    reg_wr    = 1'b1;
                    reg_dst   = is_rtype(cls) ? RDST_RD : RDST_RT;
                    wd_sel    = cls.lw ? WD_MEM : WD_ALU;
                    retire_c  = 1'b1;
                    state_nxt = ST_FETCH;
                end

                default: begin
                    state_nxt = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. The driver issues whole instructions with
// chosen wait states, pushing the per-cycle output picture each instruction should
// produce; a monitor pops and compares one entry every cycle on the falling edge.
module tb_mc_ctrl;

    localparam int unsigned CW = 4;  // narrow counter so wrap-around is exercised

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          imem_ack;
    logic          dmem_ack;
    logic          imem_req;
    logic          dmem_req;
    logic          pc_wr;
    logic          ir_wr;
    logic          reg_wr;
    logic          mem_wr;
    logic [1:0]    npc_op;
    logic [1:0]    eop;
    logic          alu_src;
    logic [2:0]    alu_op;
    logic [1:0]    reg_dst;
    logic [1:0]    wd_sel;
    logic          illegal;
    logic [CW-1:0] instr_cnt;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .reg_wr    (reg_wr),
        .mem_wr    (mem_wr),
        .npc_op    (npc_op),
        .eop       (eop),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    typedef struct packed {
        logic          imem_req;
        logic          dmem_req;
        logic          pc_wr;
        logic          ir_wr;
        logic          reg_wr;
        logic          mem_wr;
        logic [1:0]    npc_op;
        logic [1:0]    eop;
        logic          alu_src;
        logic [2:0]    alu_op;
        logic [1:0]    reg_dst;
        logic [1:0]    wd_sel;
        logic          illegal;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } exp_t;

    typedef enum int {
        K_ADDU, K_SUBU, K_NOP, K_ORI, K_LW, K_SW, K_BEQ, K_LUI,
        K_J, K_JAL, K_JR, K_ILL_OP, K_ILL_FN, K_ILL_RND
    } kind_t;

    exp_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         model_cnt   = 0;
    logic       rst_drv;
    logic [5:0] ir_op;
    logic [5:0] ir_fn;
    exp_t       mon_e;
    obs_t       mon_a;

    function automatic obs_t actual();
        obs_t a;
        a.imem_req = imem_req;
        a.dmem_req = dmem_req;
        a.pc_wr    = pc_wr;
        a.ir_wr    = ir_wr;
        a.reg_wr   = reg_wr;
        a.mem_wr   = mem_wr;
        a.npc_op   = npc_op;
        a.eop      = eop;
        a.alu_src  = alu_src;
        a.alu_op   = alu_op;
        a.reg_dst  = reg_dst;
        a.wd_sel   = wd_sel;
        a.illegal  = illegal;
        a.cnt      = instr_cnt;
        return a;
    endfunction

    // Monitor: one expected picture per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = actual();
            vectors++;
            if (mon_a !== mon_e.o) begin
                miscompares++;
                $display("FAIL %s @%0t: got %h (cnt %0d) required %h (cnt %0d)",
                         mon_e.tag, $time, mon_a, mon_a.cnt, mon_e.o, mon_e.o.cnt);
            end
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit supported_op(input logic [5:0] o);
        return o inside {6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03};
    endfunction

    // Advance one cycle: drive inputs just after the rising edge, queue the expectation
    task automatic cyc(input obs_t e, input string tag, input logic ia,
                       input logic da, input logic z);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n    = rst_drv;
        imem_ack = ia;
        dmem_ack = da;
        zero     = z;
        op       = ir_op;
        funct    = ir_fn;
        e.cnt    = CW'(model_cnt);
        x.o      = e;
        x.tag    = tag;
        exp_q.push_back(x);
    endtask

    task automatic retire();
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset(input int n);
        rst_drv   = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < n; i++) cyc('0, "reset", rnd(), rnd(), rnd());
        rst_drv   = 1'b1;
    endtask

    task automatic encode(input kind_t k);
        logic [5:0] r;
        r = 6'($urandom);
        ir_fn = r;
        case (k)
            K_ADDU:   begin ir_op = 6'h00; ir_fn = 6'h21; end
            K_SUBU:   begin ir_op = 6'h00; ir_fn = 6'h23; end
            K_NOP:    begin ir_op = 6'h00; ir_fn = 6'h00; end
            K_JR:     begin ir_op = 6'h00; ir_fn = 6'h08; end
            K_ORI:    ir_op = 6'h0D;
            K_LW:     ir_op = 6'h23;
            K_SW:     ir_op = 6'h2B;
            K_BEQ:    ir_op = 6'h04;
            K_LUI:    ir_op = 6'h0F;
            K_J:      ir_op = 6'h02;
            K_JAL:    ir_op = 6'h03;
            K_ILL_OP: ir_op = 6'h3F;
            K_ILL_FN: begin
                ir_op = 6'h00;
                while (r inside {6'h21, 6'h23, 6'h08, 6'h00}) r = 6'($urandom);
                ir_fn = r;
            end
            default: begin
                r = 6'($urandom);
                while (supported_op(r)) r = 6'($urandom);
                ir_op = r;
            end
        endcase
    endtask

    // Reference: the cycle-by-cycle control picture one instruction must produce
    task automatic run_instr(input kind_t k, input int iw, input int dw,
                             input logic z, input bit abort);
        obs_t e;
        obs_t held;
        // fetch: request held through every wait cycle, writes only with the ack
        for (int i = 0; i < iw; i++) begin
            e = '0; e.imem_req = 1'b1;
            cyc(e, "fetch_wait", 1'b0, rnd(), rnd());
        end
        e = '0; e.imem_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        cyc(e, "fetch_ack", 1'b1, rnd(), rnd());

        encode(k);
        e = '0;
        case (k)
            K_J:   begin e.pc_wr = 1'b1; e.npc_op = 2'b10; end
            K_JAL: begin
                e.pc_wr = 1'b1; e.npc_op = 2'b10;
                e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10;
            end
            K_JR:  begin e.pc_wr = 1'b1; e.npc_op = 2'b11; end
            K_ILL_OP, K_ILL_FN, K_ILL_RND: e.illegal = 1'b1;
            default: ;
        endcase
        cyc(e, "decode", rnd(), rnd(), rnd());
        if (k inside {K_J, K_JAL, K_JR, K_ILL_OP, K_ILL_FN, K_ILL_RND}) begin
            retire();
            return;
        end

        held = '0;
        case (k)
            K_SUBU: held.alu_op = 3'b001;
            K_BEQ:  held.alu_op = 3'b001;
            K_ORI:  begin held.eop = 2'b01; held.alu_src = 1'b1; held.alu_op = 3'b010; end
            K_LUI:  begin held.eop = 2'b10; held.alu_src = 1'b1; held.alu_op = 3'b011; end
            K_LW, K_SW: held.alu_src = 1'b1;
            default: ;
        endcase
        e = held;
        if (k == K_BEQ && z) begin
            e.pc_wr = 1'b1; e.npc_op = 2'b01; e.eop = 2'b11;
        end
        cyc(e, "execute", rnd(), rnd(), (k == K_BEQ) ? z : rnd());
        if (k == K_BEQ) begin
            retire();
            return;
        end

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < dw; i++) begin
                e = held; e.dmem_req = 1'b1;
                cyc(e, "mem_wait", rnd(), 1'b0, rnd());
            end
            if (abort) begin
                do_reset(2);
                return;
            end
            e = held; e.dmem_req = 1'b1; e.mem_wr = (k == K_SW);
            cyc(e, "mem_ack", rnd(), 1'b1, rnd());
            if (k == K_SW) begin
                retire();
                return;
            end
        end

        e = held;
        e.reg_wr  = 1'b1;
        e.reg_dst = (k inside {K_ADDU, K_SUBU, K_NOP}) ? 2'b01 : 2'b00;
        e.wd_sel  = (k == K_LW) ? 2'b01 : 2'b00;
        cyc(e, "writeback", rnd(), rnd(), rnd());
        retire();
    endtask

    initial begin
        kind_t k;
        int    iw;
        int    dw;
        rst_n    = 1'b0;
        rst_drv  = 1'b0;
        op       = '0;
        funct    = '0;
        zero     = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        ir_op    = '0;
        ir_fn    = '0;

        do_reset(3);
        ir_fn = '0;
        run_instr(K_ORI, 0, 0, 1'b0, 1'b0);
        run_instr(K_LW,  0, 3, 1'b0, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b0, 1'b0);
        run_instr(K_JAL, 0, 0, 1'b0, 1'b0);
        run_instr(K_ILL_OP, 0, 0, 1'b0, 1'b0);
        run_instr(K_ORI, 0, 0, 1'b0, 1'b0);
        run_instr(K_SW,  1, 3, 1'b0, 1'b1);
        run_instr(K_ORI, 0, 0, 1'b0, 1'b0);
        run_instr(K_NOP, 2, 0, 1'b0, 1'b0);
        run_instr(K_JR,  0, 0, 1'b0, 1'b0);
        run_instr(K_ILL_FN, 1, 0, 1'b0, 1'b0);
        run_instr(K_SW,  0, 0, 1'b0, 1'b0);
        run_instr(K_LUI, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            k  = kind_t'($urandom_range(0, 13));
            iw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            dw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_instr(k, iw, dw, rnd(),
                      (k == K_LW || k == K_SW) && ($urandom_range(0, 24) == 0));
        end

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
